// File: rtl/mem_stage.sv
// mem_stage: memory-access stage downstream of execute.
// Registers the execute results, issues loads and stores to data memory over a
// req/ack handshake, stalls upstream while an access is outstanding, and drives
// a single registered write-back bundle to the register file.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   - a load or store with result_I[1:0] != 0 is not issued. It retires
//               next cycle with wb_we=0, wb_data=0 and a one-cycle misalign_err.
//   undefined - misalign_err is tied 0 and the address is passed through unmodified.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid, mem_op, wb_en,    execute-stage outputs; accepted when in_valid & ~stall
//   wb_sel, dst, result_I,
//   result_F, result_P, Wdata
//   stall                       combinational: access outstanding and not acked
//   dmem_req/we/addr/wdata      data-memory request, held stable until ack
//   dmem_ack, dmem_rdata        data-memory completion and load data
//   wb_valid/we/dst/data        registered write-back bundle, wb_valid is a pulse
//   misalign_err                misaligned-access pulse (feature macro only)
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  mem_op,
    input  logic        wb_en,
    input  logic [1:0]  wb_sel,
    input  logic [4:0]  dst,
    input  logic [31:0] result_I,
    input  logic [31:0] result_F,
    input  logic        result_P,
    input  logic [31:0] Wdata,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_dst,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;

    // Request context latched at acceptance, used at completion
    logic        r_l_wb_en;
    logic        r_l_sel_load;
    logic [4:0]  r_l_dst;
    logic [31:0] r_l_data;

    // One-deep holding slot for a direct retirement that collides with a
    // memory completion on the same edge; it retires one cycle later.
    logic        r_pend_v;
    logic        r_pend_we;
    logic [4:0]  r_pend_dst;
    logic [31:0] r_pend_data;
    logic        r_pend_err;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_go_mem;
    logic        w_direct;
    logic        w_done;
    logic [31:0] w_sel_data;

    assign stall    = (r_state == S_WAIT) & ~dmem_ack;
    assign w_accept = in_valid & ~stall;
    assign w_is_mem = (mem_op == 2'b01) | (mem_op == 2'b10);
    assign w_done   = (r_state == S_WAIT) & dmem_ack;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_is_mem & (result_I[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go_mem = w_accept & w_is_mem & ~w_misalign;
    assign w_direct = w_accept & (~w_is_mem | w_misalign);

    // Write-back source mux; code 11 has no load data outside a memory op
    always_comb begin
        w_sel_data = 32'd0;
        case (wb_sel)
            2'b00:   w_sel_data = result_I;
            2'b01:   w_sel_data = result_F;
            2'b10:   w_sel_data = {31'd0, result_P};
            default: w_sel_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_l_wb_en    <= 1'b0;
            r_l_sel_load <= 1'b0;
            r_l_dst      <= 5'd0;
            r_l_data     <= 32'd0;
            r_pend_v     <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_dst   <= 5'd0;
            r_pend_data  <= 32'd0;
            r_pend_err   <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_dst       <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;

            // Retirement: memory completion first, then the held slot, then direct
            if (w_done) begin
                wb_valid <= 1'b1;
                wb_dst   <= r_l_dst;
                if (dmem_we) begin
                    wb_we   <= 1'b0;
                    wb_data <= 32'd0;
                end else begin
                    wb_we   <= r_l_wb_en;
                    wb_data <= r_l_sel_load ? dmem_rdata : r_l_data;
                end
            end else if (r_pend_v) begin
                wb_valid     <= 1'b1;
                wb_we        <= r_pend_we;
                wb_dst       <= r_pend_dst;
                wb_data      <= r_pend_data;
                misalign_err <= r_pend_err;
            end else if (w_direct) begin
                wb_valid     <= 1'b1;
                wb_we        <= wb_en & ~w_misalign;
                wb_dst       <= dst;
                wb_data      <= w_misalign ? 32'd0 : w_sel_data;
                misalign_err <= w_misalign;
            end

            // A direct op must wait whenever the output slot is taken this edge
            r_pend_v <= w_direct & (w_done | r_pend_v);
            if (w_direct) begin
                r_pend_we   <= wb_en & ~w_misalign;
                r_pend_dst  <= dst;
                r_pend_data <= w_misalign ? 32'd0 : w_sel_data;
                r_pend_err  <= w_misalign;
            end

            // Memory request side
            if (w_go_mem) begin
                r_state      <= S_WAIT;
                dmem_req     <= 1'b1;
                dmem_we      <= (mem_op == 2'b10);
                dmem_addr    <= result_I;
                dmem_wdata   <= Wdata;
                r_l_wb_en    <= wb_en;
                r_l_sel_load <= (wb_sel == 2'b11);
                r_l_dst      <= dst;
                r_l_data     <= w_sel_data;
            end else if (w_done) begin
                r_state  <= S_IDLE;
                dmem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  mem_op;
    logic        wb_en;
    logic [1:0]  wb_sel;
    logic [4:0]  dst;
    logic [31:0] result_I;
    logic [31:0] result_F;
    logic        result_P;
    logic [31:0] Wdata;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .mem_op       (mem_op),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .dst          (dst),
        .result_I     (result_I),
        .result_F     (result_F),
        .result_P     (result_P),
        .Wdata        (Wdata),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mem_op;
        logic        wb_en;
        logic [1:0]  wb_sel;
        logic [4:0]  dst;
        logic [31:0] rI;
        logic [31:0] rF;
        logic        rP;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic en,
                         input logic [1:0] sel, input logic [4:0] d,
                         input logic [31:0] rI, input logic [31:0] wd);
        in_valid = v;
        mem_op   = op;
        wb_en    = en;
        wb_sel   = sel;
        dst      = d;
        result_I = rI;
        Wdata    = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        // op, en, sel, dst, rI, rF, rP, exp_we, exp_data
        vecs[0] = '{2'b00, 1'b1, 2'b00, 5'd5,  32'h0000_1234, 32'h0,         1'b0, 1'b1, 32'h0000_1234};
        vecs[1] = '{2'b00, 1'b1, 2'b01, 5'd6,  32'h1111_1111, 32'h3F80_0000, 1'b0, 1'b1, 32'h3F80_0000};
        vecs[2] = '{2'b00, 1'b1, 2'b10, 5'd7,  32'h2222_2222, 32'h4444_4444, 1'b1, 1'b1, 32'h0000_0001};
        vecs[3] = '{2'b00, 1'b1, 2'b11, 5'd8,  32'h3333_3333, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4] = '{2'b11, 1'b1, 2'b00, 5'd9,  32'hABCD_0000, 32'h0,         1'b0, 1'b1, 32'hABCD_0000};
        vecs[5] = '{2'b00, 1'b0, 2'b01, 5'd31, 32'h0,         32'h7777_7777, 1'b0, 1'b0, 32'h7777_7777};

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        result_F = 32'h0; result_P = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);

        // Reset state
        tick(); tick();
        @(negedge clk) rst = 1'b0;
        tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);

        // Ack while IDLE is ignored
        @(negedge clk) dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk) dmem_ack = 1'b0;
        tick();
        chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_ack_wb_data", wb_data, 32'd0);

        // Non-memory ops, table driven
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].mem_op, vecs[i].wb_en, vecs[i].wb_sel, vecs[i].dst, vecs[i].rI, 32'h0);
            result_F = vecs[i].rF;
            result_P = vecs[i].rP;
            tick();
            chk($sformatf("alu%0d_valid", i), 32'(wb_valid), 32'd1);
            chk($sformatf("alu%0d_we", i), 32'(wb_we), 32'(vecs[i].exp_we));
            chk($sformatf("alu%0d_dst", i), 32'(wb_dst), 32'(vecs[i].dst));
            chk($sformatf("alu%0d_data", i), wb_data, vecs[i].exp_data);
            chk($sformatf("alu%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("alu%0d_req", i), 32'(dmem_req), 32'd0);
        end
        @(negedge clk) in_valid = 1'b0;
        tick();
        chk("hold_valid", 32'(wb_valid), 32'd0);
        chk("hold_data", wb_data, 32'h7777_7777);
        chk("hold_dst", 32'(wb_dst), 32'd31);

        // Load with 3-cycle ack delay
        @(negedge clk) drive(1'b1, 2'b01, 1'b1, 2'b11, 5'd10, 32'h0000_0100, 32'h0);
        tick();
        @(negedge clk) in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("ld_wait%0d_req", c), 32'(dmem_req), 32'd1);
            chk($sformatf("ld_wait%0d_addr", c), dmem_addr, 32'h0000_0100);
            chk($sformatf("ld_wait%0d_we", c), 32'(dmem_we), 32'd0);
            chk($sformatf("ld_wait%0d_stall", c), 32'(stall), 32'd1);
            tick();
        end
        @(negedge clk) dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_ack_req", 32'(dmem_req), 32'd1);
        chk("ld_ack_addr", dmem_addr, 32'h0000_0100);
        chk("ld_ack_stall", 32'(stall), 32'd0);
        tick();
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_we", 32'(wb_we), 32'd1);
        chk("ld_wb_dst", 32'(wb_dst), 32'd10);
        chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("ld_req_drop", 32'(dmem_req), 32'd0);
        @(negedge clk) dmem_ack = 1'b0;
        tick();
        chk("ld_pulse_once", 32'(wb_valid), 32'd0);

        // Store then load, immediate acks, req stays high
        @(negedge clk) drive(1'b1, 2'b10, 1'b1, 2'b00, 5'd11, 32'h0000_0200, 32'h0000_55AA);
        tick();
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_addr", dmem_addr, 32'h0000_0200);
        chk("st_wdata", dmem_wdata, 32'h0000_55AA);
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b1, 2'b11, 5'd12, 32'h0000_0204, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        tick();
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_we", 32'(wb_we), 32'd0);
        chk("st_wb_data", wb_data, 32'd0);
        chk("b2b_req", 32'(dmem_req), 32'd1);
        chk("b2b_we", 32'(dmem_we), 32'd0);
        chk("b2b_addr", dmem_addr, 32'h0000_0204);
        @(negedge clk) in_valid = 1'b0; dmem_rdata = 32'hCAFE_F00D;
        tick();
        chk("b2b_ld_valid", 32'(wb_valid), 32'd1);
        chk("b2b_ld_we", 32'(wb_we), 32'd1);
        chk("b2b_ld_dst", 32'(wb_dst), 32'd12);
        chk("b2b_ld_data", wb_data, 32'hCAFE_F00D);
        chk("b2b_req_drop", 32'(dmem_req), 32'd0);
        @(negedge clk) dmem_ack = 1'b0;

        // Load returning a latched ALU source, with an ALU op accepted on the ack edge
        @(negedge clk) drive(1'b1, 2'b01, 1'b1, 2'b00, 5'd13, 32'h0000_0300, 32'h0);
        tick();
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b1, 2'b00, 5'd14, 32'h0000_0042, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
        tick();
        chk("mix_ld_valid", 32'(wb_valid), 32'd1);
        chk("mix_ld_dst", 32'(wb_dst), 32'd13);
        chk("mix_ld_data", wb_data, 32'h0000_0300);
        chk("mix_req_drop", 32'(dmem_req), 32'd0);
        @(negedge clk) in_valid = 1'b0; dmem_ack = 1'b0;
        tick();
        chk("mix_alu_valid", 32'(wb_valid), 32'd1);
        chk("mix_alu_dst", 32'(wb_dst), 32'd14);
        chk("mix_alu_data", wb_data, 32'h0000_0042);
        tick();
        chk("mix_quiet", 32'(wb_valid), 32'd0);

        // Reset while WAIT abandons the access
        @(negedge clk) drive(1'b1, 2'b01, 1'b1, 2'b11, 5'd15, 32'h0000_0400, 32'h0);
        tick();
        chk("rw_req", 32'(dmem_req), 32'd1);
        @(negedge clk) in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("rw_req_drop", 32'(dmem_req), 32'd0);
        chk("rw_no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk) rst = 1'b0; dmem_ack = 1'b1;
        tick();
        chk("rw_stall", 32'(stall), 32'd0);
        @(negedge clk) dmem_ack = 1'b0;
        tick();
        chk("rw_ack_ignored", 32'(wb_valid), 32'd0);
        @(negedge clk) drive(1'b1, 2'b00, 1'b1, 2'b00, 5'd16, 32'h0000_0777, 32'h0);
        tick();
        chk("rw_alu_valid", 32'(wb_valid), 32'd1);
        chk("rw_alu_data", wb_data, 32'h0000_0777);
        @(negedge clk) in_valid = 1'b0;

        // Misaligned load
        @(negedge clk) drive(1'b1, 2'b01, 1'b1, 2'b11, 5'd3, 32'h0000_0102, 32'h0);
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_no_req", 32'(dmem_req), 32'd0);
        chk("mis_valid", 32'(wb_valid), 32'd1);
        chk("mis_we", 32'(wb_we), 32'd0);
        chk("mis_data", wb_data, 32'd0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_stall", 32'(stall), 32'd0);
        @(negedge clk) in_valid = 1'b0;
        tick();
        chk("mis_err_pulse", 32'(misalign_err), 32'd0);
`else
        chk("una_req", 32'(dmem_req), 32'd1);
        chk("una_addr", dmem_addr, 32'h0000_0102);
        chk("una_err", 32'(misalign_err), 32'd0);
        @(negedge clk) in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        tick();
        chk("una_wb_data", wb_data, 32'h0BAD_F00D);
        chk("una_err_after", 32'(misalign_err), 32'd0);
        @(negedge clk) dmem_ack = 1'b0;
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage that sits directly downstream of the execution stage. It registers the integer, float and predicate results and the store data produced by execution. Loads and stores are issued to the data memory over a req/ack handshake, and the stage stalls upstream while an access is outstanding. It delivers a single registered write-back bundle to the register-file write port.

## Interface

Parameters:
- none.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: the execution outputs below are valid this cycle.
- `mem_op` in 2: 00 none, 01 load word, 10 store word, 11 treated as none.
- `wb_en` in 1: instruction writes a register.
- `wb_sel` in 2: source for write-back data. 00 `result_I`, 01 `result_F`, 10 `{31'b0,result_P}`, 11 load data.
- `dst` in 5: destination register index.
- `result_I` in 32: integer ALU result; also the memory byte address.
- `result_F` in 32: float result.
- `result_P` in 1: predicate result.
- `Wdata` in 32: store data.
- `stall` out 1: upstream must hold its outputs this cycle.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: memory address.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: request completes this cycle.
- `dmem_rdata` in 32: load data, valid with `dmem_ack`.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_we` out 1: register write enable, qualified by `wb_valid`.
- `wb_dst` out 5: register index.
- `wb_data` out 32: write-back data.
- `misalign_err` out 1: misaligned-access pulse (see Configuration).

## Operation

- FSM has two states: IDLE and WAIT.
- An instruction is accepted at any rising edge where `in_valid`=1 and `stall`=0.
  - Accepting in IDLE or in WAIT on the ack cycle behaves identically.
- Accepted instruction with `mem_op` none or 11:
  - Next cycle: `wb_valid`=1, `wb_we`=`wb_en`, `wb_dst`=`dst`, `wb_data` selected by `wb_sel`.
  - `wb_sel`=11 on a non-memory op gives `wb_data`=0.
  - State stays or returns to IDLE.
- Accepted load or store:
  - Latch address, store data, we, dst, `wb_en` and `wb_sel`.
  - Next cycle: state WAIT with `dmem_req`=1.
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stay stable until the ack cycle.
- WAIT with `dmem_ack`=1, completion on that edge:
  - Load: `wb_valid`=1, `wb_we`=latched `wb_en`, `wb_data`=`dmem_rdata` when latched `wb_sel`=11, else the latched selected source.
  - Store: `wb_valid`=1, `wb_we`=0, `wb_data`=0.
  - Without a new acceptance on the same edge, `dmem_req` drops and state goes to IDLE.
  - A new memory op accepted on the same edge keeps `dmem_req`=1 with new address/data and state stays WAIT.
  - A new non-memory op accepted on the same edge makes state IDLE; its wb pulse follows one cycle after the load/store pulse.
- `stall` = (state==WAIT) & ~`dmem_ack`. It is combinational and has no dependence on `in_valid`.
- `dmem_ack` is ignored in IDLE.
- `wb_valid` is a single-cycle pulse. Other wb outputs hold their last value when `wb_valid`=0.

## Timing

- Reset values: state IDLE; all outputs 0 (`stall`=0, `dmem_req`=0, `wb_valid`=0, `wb_data`=0, `misalign_err`=0).
- Reset in WAIT: the pending access is abandoned, `dmem_req`=0 the next cycle, and no `wb_valid` is issued for it.
- Non-memory latency: 1 cycle from acceptance to `wb_valid`. Throughput is 1 per cycle.
- Memory latency: `dmem_req` rises 1 cycle after acceptance. `wb_valid` occurs 1 cycle after the ack edge. Minimum total is 2 cycles, with ack in the first req cycle.
- Back-to-back memory ops with immediate ack sustain 1 access per cycle, with `dmem_req` held continuously high.

## Configuration

- `MEM_ALIGN_CHECK_EN` defined:
  - A load or store with `result_I[1:0]`!=0 issues no request and does not enter WAIT.
  - Next cycle: `wb_valid`=1, `wb_we`=0, `wb_data`=0, `misalign_err`=1 for exactly that cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misalign_err` is tied 0.
  - The address is passed to `dmem_addr` unmodified.

## Test plan

- Reset: after `rst`=1 then 0, all outputs are 0. An ack pulse while IDLE produces no `wb_valid`.
- ALU op: `mem_op`=00, `wb_sel`=00, `result_I`=0x1234, `dst`=5, `wb_en`=1 → next cycle `wb_valid`=1, `wb_we`=1, `wb_dst`=5, `wb_data`=0x1234, `stall`=0.
- Load with 3-cycle ack delay: `result_I`=0x100 → `dmem_req`=1 with `dmem_addr`=0x100 for 3 cycles and `stall`=1 on the first 2. After ack with `dmem_rdata`=0xDEADBEEF, `wb_data`=0xDEADBEEF, `wb_we`=1.
- Store followed by a load with immediate acks: `dmem_req` stays high across both; `dmem_we` goes 1 then 0; two `wb_valid` pulses, the first with `wb_we`=0.
- Reset in WAIT: `dmem_req` drops and no `wb_valid` follows. A subsequent ALU op retires normally.
- `MEM_ALIGN_CHECK_EN` defined: load to 0x102 → no `dmem_req`; `misalign_err`=1 and `wb_valid`=1 with `wb_we`=0 next cycle.
